// File: rtl/cuckoo_lookup_sched.sv
// cuckoo_lookup_sched
// Schedules payload windows into the fixed-latency dual (case/nocase) cuckoo
// lookup pipeline. It issues at most one window per cycle and follows each one
// through the pipeline with a tag shift register. Hits, with their byte offsets,
// are collected into a first-word-fall-through result FIFO. A credit counter
// stops issue before the FIFO could overflow, and the pipeline is drained at
// end of packet.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         payload window handshake (in_ready is combinational)
//   in_data, in_sop, in_eop   window (bits [7:0] newest byte) and packet framing
//   lk_enable, lk_fifo_in     registered issue into lookup stage 1
//   lk_compare_out[_nocase]   per-slot hit flags, LAT cycles after lk_enable
//   lk_suffix[_nocase]        suffix codes, aligned with the hit flags
//   res_valid/res_ready       result FIFO handshake
//   res_offset/hit/suffix     head-of-FIFO result; hit/suffix = {nocase, case}
//   pkt_done                  one-cycle pulse once a packet has fully retired
//   busy                      scheduler is not IDLE
module cuckoo_lookup_sched #(
  parameter int unsigned LAT       = 4,
  parameter int unsigned RES_DEPTH = 8,
  parameter int unsigned OFF_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [159:0]     in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             lk_enable,
  output logic [159:0]     lk_fifo_in,
  input  logic [1:0]       lk_compare_out,
  input  logic [1:0]       lk_compare_out_nocase,
  input  logic [1:0]       lk_suffix,
  input  logic [1:0]       lk_suffix_nocase,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OFF_W-1:0] res_offset,
  output logic [3:0]       res_hit,
  output logic [3:0]       res_suffix,
  output logic             pkt_done,
  output logic             busy
);

  localparam int unsigned CRD_W = $clog2(RES_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(RES_DEPTH);
  localparam int unsigned DRN_W = $clog2(LAT + 2);
  localparam int unsigned ENT_W = OFF_W + 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [CRD_W-1:0]   credits;
  logic [OFF_W-1:0]   off_cnt;     // offset of the most recently issued window
  logic [DRN_W-1:0]   drain_cnt;

  logic [LAT:0]       tag_vld;
  logic [OFF_W-1:0]   tag_off [LAT+1];

  logic [ENT_W-1:0]   mem [RES_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [ENT_W-1:0]   rd_ent;

  logic               accept;
  logic               issue;
  logic [OFF_W-1:0]   issue_off;
  logic               any_hit;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               slot_free;

  // Input handshake: an IDLE non-sop beat is always swallowed, issuing needs a credit
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = (credits != '0) | ~in_sop;
      RUN:     in_ready = (credits != '0);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign issue  = accept & ((state == RUN) | ((state == IDLE) & in_sop));

  // Offset of the window being issued this cycle; saturates at all-ones
  always_comb begin
    issue_off = '0;
    if (state == RUN) begin
      issue_off = (&off_cnt) ? off_cnt : off_cnt + OFF_W'(1);
    end
  end

  // Retire side: tag slot LAT lines up with the pipeline outputs
  assign any_hit   = |(lk_compare_out | lk_compare_out_nocase);
  assign fifo_wr   = tag_vld[LAT] & any_hit;
  assign slot_free = tag_vld[LAT] & ~any_hit;
  assign fifo_rd   = res_valid & res_ready;

  // Scheduler FSM and issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      off_cnt    <= '0;
      drain_cnt  <= '0;
      lk_enable  <= 1'b0;
      lk_fifo_in <= '0;
      pkt_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lk_enable <= issue;
      pkt_done  <= 1'b0;
      if (issue) begin
        lk_fifo_in <= in_data;
        off_cnt    <= issue_off;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            busy <= 1'b1;
            if (in_eop) begin
              state     <= DRAIN;
              drain_cnt <= DRN_W'(LAT + 1);
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept && in_eop) begin
            state     <= DRAIN;
            drain_cnt <= DRN_W'(LAT + 1);
          end
        end
        DRAIN: begin
          // Counter reaching zero means the last issued window has retired
          if (drain_cnt <= DRN_W'(1)) begin
            drain_cnt <= '0;
            pkt_done  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Credits: one per FIFO slot, held by a window from issue until it frees its slot
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRD_W'(RES_DEPTH);
    end else begin
      credits <= credits + CRD_W'(slot_free) + CRD_W'(fifo_rd) - CRD_W'(issue);
    end
  end

  // Tag shift register; entry 0 loads alongside lk_enable
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i <= int'(LAT); i++) begin
        tag_off[i] <= '0;
      end
    end else begin
      tag_vld    <= {tag_vld[LAT-1:0], issue};
      tag_off[0] <= issue_off;
      for (int i = 1; i <= int'(LAT); i++) begin
        tag_off[i] <= tag_off[i-1];
      end
    end
  end

  // Result FIFO, first-word-fall-through
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(RES_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (fifo_wr) begin
        mem[wr_ptr[PTR_W-1:0]] <= {tag_off[LAT], lk_compare_out_nocase, lk_compare_out,
                                   lk_suffix_nocase, lk_suffix};
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  assign rd_ent     = mem[rd_ptr[PTR_W-1:0]];
  assign res_valid  = (wr_ptr != rd_ptr);
  assign res_offset = rd_ent[ENT_W-1 -: OFF_W];
  assign res_hit    = rd_ent[7:4];
  assign res_suffix = rd_ent[3:0];

endmodule

// File: tb/tb_cuckoo_lookup_sched.sv
// Bench for cuckoo_lookup_sched: randomized windows, a behavioural lookup
// pipeline whose hit/suffix codes come from the window's low byte, and a
// scoreboard of expected issues, results and pkt_done pulses.
module tb_cuckoo_lookup_sched;
  localparam int unsigned LAT       = 4;
  localparam int unsigned RES_DEPTH = 8;
  localparam int unsigned OFF_W     = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [159:0]     in_data;
  logic             in_sop;
  logic             in_eop;
  logic             lk_enable;
  logic [159:0]     lk_fifo_in;
  logic [1:0]       lk_compare_out;
  logic [1:0]       lk_compare_out_nocase;
  logic [1:0]       lk_suffix;
  logic [1:0]       lk_suffix_nocase;
  logic             res_valid;
  logic             res_ready;
  logic [OFF_W-1:0] res_offset;
  logic [3:0]       res_hit;
  logic [3:0]       res_suffix;
  logic             pkt_done;
  logic             busy;

  cuckoo_lookup_sched #(.LAT(LAT), .RES_DEPTH(RES_DEPTH), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .lk_enable(lk_enable), .lk_fifo_in(lk_fifo_in),
    .lk_compare_out(lk_compare_out), .lk_compare_out_nocase(lk_compare_out_nocase),
    .lk_suffix(lk_suffix), .lk_suffix_nocase(lk_suffix_nocase),
    .res_valid(res_valid), .res_ready(res_ready), .res_offset(res_offset),
    .res_hit(res_hit), .res_suffix(res_suffix),
    .pkt_done(pkt_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lookup pipeline: window byte [3:0] = {nocase,case} hits, [7:4] = suffixes.
  // Bubble slots carry random junk that must be ignored.
  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= lk_enable ? lk_fifo_in[7:0] : 8'($urandom);
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign lk_compare_out        = pipe[LAT-1][1:0];
  assign lk_compare_out_nocase = pipe[LAT-1][3:2];
  assign lk_suffix             = pipe[LAT-1][5:4];
  assign lk_suffix_nocase      = pipe[LAT-1][7:6];

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [3:0]       hit;
    logic [3:0]       suf;
  } res_t;

  res_t         res_q[$];
  int           lk_cyc_q[$];
  logic [159:0] lk_dat_q[$];
  int           done_q[$];

  int total = 0;
  int bad   = 0;
  int rr_mode = 1;
  int last_acc = 0;

  bit               m_in_pkt = 1'b0;
  logic [OFF_W-1:0] m_off = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Monitor: compares every issue, result pop and pkt_done against the queues
  always @(negedge clk) begin : mon
    res_t         e;
    int           c;
    logic [159:0] d;
    if (!rst) begin
      if (lk_enable) begin
        if (lk_cyc_q.size() == 0) check("lk_enable_unexpected", 1, 0);
        else begin
          c = lk_cyc_q.pop_front();
          d = lk_dat_q.pop_front();
          check("lk_enable_cycle", cyc, c);
          check("lk_fifo_in", lk_fifo_in, d);
        end
      end else if (lk_cyc_q.size() != 0 && lk_cyc_q[0] <= cyc) begin
        check("lk_enable_missing", 0, 1);
        c = lk_cyc_q.pop_front();
        d = lk_dat_q.pop_front();
      end
      if (pkt_done) begin
        if (done_q.size() == 0) check("pkt_done_unexpected", 1, 0);
        else begin
          c = done_q.pop_front();
          check("pkt_done_cycle", cyc, c);
        end
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        check("pkt_done_missing", 0, 1);
        c = done_q.pop_front();
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) check("res_unexpected", {res_offset, res_hit, res_suffix}, 0);
        else begin
          e = res_q.pop_front();
          check("res_offset", res_offset, e.off);
          check("res_hit", res_hit, e.hit);
          check("res_suffix", res_suffix, e.suf);
        end
      end
    end
  end

  function automatic logic [159:0] mkdata(input logic [3:0] hit, input logic [3:0] suf);
    logic [159:0] d;
    for (int i = 0; i < 5; i++) d[i*32 +: 32] = $urandom;
    d[7:0] = {suf, hit};
    return d;
  endfunction

  // Reference behaviour for one accepted beat
  task automatic model_accept(input logic [159:0] d, input bit sop, input bit eop);
    bit iss = 1'b0;
    if (!m_in_pkt) begin
      if (sop) begin
        m_off = '0;
        iss = 1'b1;
        if (eop) done_q.push_back(cyc + int'(LAT) + 2);
        else m_in_pkt = 1'b1;
      end
    end else begin
      if (m_off != {OFF_W{1'b1}}) m_off = m_off + OFF_W'(1);
      iss = 1'b1;
      if (eop) begin
        done_q.push_back(cyc + int'(LAT) + 2);
        m_in_pkt = 1'b0;
      end
    end
    if (iss) begin
      lk_cyc_q.push_back(cyc + 1);
      lk_dat_q.push_back(d);
      if (d[3:0] != 4'h0) res_q.push_back(res_t'({m_off, d[3:0], d[7:4]}));
    end
  endtask

  // Offer one beat for one cycle; call at posedge+1, returns at posedge+1
  task automatic try_cycle(input logic [159:0] d, input bit sop, input bit eop, output bit acc);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      last_acc = cyc;
      model_accept(d, sop, eop);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drive_beat(input logic [159:0] d, input bit sop, input bit eop);
    bit acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) try_cycle(d, sop, eop, acc);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_quiet(input int bound);
    int i = 0;
    while (i < bound && (busy || res_q.size() != 0 || lk_cyc_q.size() != 0 || done_q.size() != 0)) begin
      idle_cycles(1);
      i++;
    end
    if (i >= bound) check("drain_timeout", 0, 1);
  endtask

  task automatic single_window();
    logic [159:0] d;
    int t;
    rr_mode = 1;
    wait_quiet(300);
    d = mkdata(4'b0001, 4'b0010);
    drive_beat(d, 1'b1, 1'b1);
    t = last_acc;
    do @(negedge clk); while (cyc < t + int'(LAT) + 1);
    check("sw_res_valid_early", res_valid, 0);
    @(negedge clk);
    check("sw_res_valid", res_valid, 1);
    check("sw_res_offset", res_offset, 0);
    check("sw_res_hit", res_hit, 4'b0001);
    check("sw_res_suffix", res_suffix, 4'b0010);
    check("sw_pkt_done", pkt_done, 1);
    check("sw_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic backpressure();
    bit acc;
    int n = 0;
    rr_mode = 1;
    wait_quiet(300);
    rr_mode = 0;
    for (int i = 0; i < 14; i++) begin
      try_cycle(mkdata(4'($urandom_range(1, 15)), 4'($urandom)), (n == 0), 1'b0, acc);
      if (acc) n++;
    end
    check("bp_accepts", n, RES_DEPTH);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_res_valid", res_valid, 1);
    @(posedge clk);
    #1;
    rr_mode = 1;
    for (int i = 0; i < 8; i++)
      drive_beat(mkdata(4'($urandom_range(1, 15)), 4'($urandom)), 1'b0, (i == 7));
    wait_quiet(300);
  endtask

  initial begin
    bit acc;
    int first;
    int len;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_lk_enable", lk_enable, 0);
    check("rst_lk_fifo_in", lk_fifo_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_fields", {res_offset, res_hit, res_suffix}, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    single_window();

    // 20-window packet, hits on windows 3 (case) and 17 (nocase 2'b10)
    rr_mode = 1;
    for (int i = 0; i < 20; i++) begin
      drive_beat(mkdata((i == 3) ? 4'b0001 : (i == 17) ? 4'b1000 : 4'b0000, 4'($urandom)),
                 (i == 0), (i == 19));
      if (i == 0) first = last_acc;
    end
    check("p20_no_gaps", last_acc - first, 19);
    wait_quiet(300);

    backpressure();

    // Bubbles: one idle cycle after every window
    rr_mode = 2;
    for (int i = 0; i < 10; i++) begin
      drive_beat(mkdata(($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                        4'($urandom)), (i == 0), (i == 9));
      idle_cycles(1);
    end
    rr_mode = 1;
    wait_quiet(300);

    // Non-sop beats in IDLE are swallowed
    for (int i = 0; i < 3; i++) begin
      try_cycle(mkdata(4'hf, 4'($urandom)), 1'b0, 1'($urandom), acc);
      check("disc_accept", acc, 1);
    end
    @(negedge clk);
    check("disc_busy", busy, 0);
    @(posedge clk);
    #1;
    idle_cycles(int'(LAT) + 3);

    // Random packets with gaps, stray sops, junk beats and random res_ready
    rr_mode = 2;
    for (int p = 0; p < 8; p++) begin
      if ($urandom_range(0, 2) == 0) drive_beat(mkdata(4'hf, 4'h0), 1'b0, 1'($urandom));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        drive_beat(mkdata(($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                          4'($urandom)),
                   (i == 0) || ($urandom_range(0, 5) == 0), (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
      end
    end
    rr_mode = 1;
    wait_quiet(500);

    // Reset in RUN with results queued and windows in flight
    rr_mode = 0;
    for (int i = 0; i < 5; i++)
      drive_beat(mkdata(4'($urandom_range(1, 15)), 4'($urandom)), (i == 0), 1'b0);
    idle_cycles(2);
    rst = 1'b1;
    res_q.delete();
    lk_cyc_q.delete();
    lk_dat_q.delete();
    done_q.delete();
    m_in_pkt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr_mode = 1;
    @(negedge clk);
    check("rr_res_valid", res_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    idle_cycles(int'(LAT) + 3);
    single_window();
    backpressure();

    wait_quiet(500);
    check("end_res_q", res_q.size(), 0);
    check("end_lk_q", lk_cyc_q.size(), 0);
    check("end_done_q", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
